if_stage: RTL
=============

# if_stage

Instruction-fetch stage: the upstream producer of the `PC_IF`/`IR_IF` valid/ready stream that the decode stage consumes. It also applies decode-time branch predictions (`jump_pred_IF`/`jump_addr_IF`) and flush redirects from later stages. It drives a single-outstanding instruction-memory read port and reports fetch exceptions (misaligned PC, access fault) as `exc_pend_IF`/`exc_cause_IF`. It sits between the instruction memory and the decode stage, and imports `CPU_pkg` for the cause constants.

## Interface
- `RESET_VEC`, `32'h00000000`, PC of the first fetch after reset
- `clk`  in  1  clock; all state changes on its rising edge
- `reset`  in  1  one clock; reset is synchronous and active-low
- `valid_out`  out  1  fetch output register holds an instruction
- `ready_in`  in  1  decode stage accepts (decode's `ready_out`)
- `flush_in`  in  1  redirect request from later stages
- `flush_addr`  in  32  redirect target, sampled when `flush_in`=1
- `PC_IF`  out  32  PC of presented instruction
- `IR_IF`  out  32  presented instruction word
- `exc_pend_IF`  out  1  presented entry carries a fetch exception
- `exc_cause_IF`  out  32  cause code when `exc_pend_IF`=1, else 0
- `jump_pred_IF`  in  1  decode predicts the presented instruction jumps
- `jump_addr_IF`  in  32  predicted target
- `imem_rena`  out  1  read request, held until `imem_ready`
- `imem_addr`  out  32  read address, stable while `imem_rena`=1
- `imem_rdata`  in  32  read data, valid with `imem_ready`
- `imem_ready`  in  1  one-cycle response strobe
- `imem_error`  in  1  access fault, qualified by `imem_ready`

## Operation
- Registers: `state`, `pc` (next fetch PC), `imem_addr`, the output register (`valid_out`, `PC_IF`, `IR_IF`, `exc_pend_IF`, `exc_cause_IF`).
- `imem_rena` is combinational: it is 1 exactly in FETCH and KILL.
- IDLE (reset state):
  - `pc[1:0]`≠0: load the output register with `valid_out`=1, `PC_IF`=`pc`, `IR_IF`=0, `exc_pend_IF`=1, `exc_cause_IF`=`CAUSE_MISALIGNED_INST` (0); go to FULL. No request is issued.
  - Otherwise: `imem_addr`←`pc`; go to FETCH.
- FETCH: wait for `imem_ready`.
  - Good response (`imem_error`=0): `PC_IF`←`imem_addr`, `IR_IF`←`imem_rdata`, `exc_pend_IF`←0, `valid_out`←1; go to FULL.
  - Faulting response (`imem_error`=1): `IR_IF`←0, `exc_pend_IF`←1, `exc_cause_IF`←`CAUSE_INST_ACCESS_FAULT` (1), `valid_out`←1; go to FULL.
- FULL: on `ready_in`=1 (transfer):
  - `valid_out`←0 and all output fields ←0.
  - If the transferred entry had `exc_pend_IF`=1: go to HALT.
  - Otherwise: `pc`←(`jump_pred_IF` ? `jump_addr_IF` : `PC_IF`+4, mod 2^32); go to IDLE.
  - `jump_pred_IF`/`jump_addr_IF` are sampled only in the transfer cycle.
- HALT: no requests; wait for `flush_in`.
- KILL: a request is outstanding but its result is stale. Keep `imem_rena`/`imem_addr` unchanged; on `imem_ready`, discard data and error, go to IDLE.
- Flush (`flush_in`=1) has priority over everything, including a same-cycle transfer or response:
  - `pc`←`flush_addr`; `valid_out` and all output fields ←0.
  - State: FETCH without `imem_ready` → KILL; KILL without `imem_ready` → KILL. Every other case (IDLE, FULL, HALT, or FETCH/KILL with `imem_ready`) → IDLE.
  - Repeated flushes during KILL: the last `flush_addr` wins.
- Reset (active cycle) overrides flush. State←IDLE, `pc`←`RESET_VEC`, `imem_addr`←`RESET_VEC`, `valid_out`/`PC_IF`/`IR_IF`/`exc_pend_IF`/`exc_cause_IF`←0, so `imem_rena`=0.
- Reset mid-request abandons the request. The memory must also be reset.

## Timing
- Reset released at edge E: IDLE in cycle E; `imem_rena`=1 with `imem_addr`=`RESET_VEC` from cycle E+1.
- Request issued in cycle R, `imem_ready` in cycle R+L (L≥0): `valid_out`=1 in cycle R+L+1.
- Transfer in cycle T: next request in cycle T+2 (IDLE at T+1). Steady-state throughput is one instruction per L+3 cycles.
- Flush in cycle F, no outstanding request: request to `flush_addr` in cycle F+2.
- Flush while waiting: the request stays until `imem_ready` in cycle K; the redirected request follows in cycle K+2.
- `valid_out` never drops without a transfer or a flush. Output fields are stable while `valid_out`=1 and `ready_in`=0.

## Test plan
- Reset with `RESET_VEC`=0x100, memory L=0 returning 0x00000013, `ready_in`=1: fetch addresses 0x100, 0x104, 0x108; `PC_IF` follows them; one transfer every 3 cycles.
- `jump_pred_IF`=1, `jump_addr_IF`=0x200 during transfer of PC 0x104: next `imem_addr`=0x200, and PC 0x108 is never requested.
- `ready_in`=0 for 5 cycles with `valid_out`=1: `PC_IF`/`IR_IF` held, `imem_rena`=0 throughout; transfer on release.
- Flush to 0x400 two cycles into an L=4 request at 0x10C: request held at 0x10C until `imem_ready`, no `valid_out`; next request 0x400.
- `imem_error`=1 at 0x110: `exc_pend_IF`=1, cause 1; after transfer, no requests until a flush to 0x80 restarts fetch at 0x80.
- Flush to 0x202: entry with PC 0x202, cause 0, no `imem_rena` pulse; flush plus reset in the same cycle: reset wins, next fetch at `RESET_VEC`.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues single-outstanding instruction-memory reads,
// presents fetched words to decode over a valid/ready handshake, applies
// decode-time jump predictions and later-stage flush redirects, and reports
// fetch exceptions (misaligned PC, access fault).

package CPU_pkg;
    localparam logic [31:0] CAUSE_MISALIGNED_INST   = 32'd0;
    localparam logic [31:0] CAUSE_INST_ACCESS_FAULT = 32'd1;
endpackage

module if_stage
    import CPU_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    // decode-side stream
    output logic        valid_out,
    input  logic        ready_in,
    output logic [31:0] PC_IF,
    output logic [31:0] IR_IF,
    output logic        exc_pend_IF,
    output logic [31:0] exc_cause_IF,
    input  logic        jump_pred_IF,
    input  logic [31:0] jump_addr_IF,
    // redirect from later stages
    input  logic        flush_in,
    input  logic [31:0] flush_addr,
    // instruction memory
    output logic        imem_rena,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        imem_error
);

    // IDLE : decide whether to fetch pc or report it as misaligned
    // FETCH: request outstanding, result wanted
    // FULL : output register holds an entry for decode
    // HALT : a faulting entry was consumed; only a flush restarts fetch
    // KILL : request outstanding, result is stale and will be dropped
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        FULL  = 3'd2,
        HALT  = 3'd3,
        KILL  = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] pc;

    // The memory request must stay asserted for the whole wait, including
    // while a stale result is being drained after a flush.
    assign imem_rena = (state == FETCH) || (state == KILL);

    // Fetch sequencing, output register and redirect handling.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            pc           <= RESET_VEC;
            imem_addr    <= RESET_VEC;
            valid_out    <= 1'b0;
            PC_IF        <= 32'd0;
            IR_IF        <= 32'd0;
            exc_pend_IF  <= 1'b0;
            exc_cause_IF <= 32'd0;
        end else if (flush_in) begin
            // A flush beats any same-cycle transfer or memory response.
            // imem_addr is left alone so an in-flight request stays stable.
            pc           <= flush_addr;
            valid_out    <= 1'b0;
            PC_IF        <= 32'd0;
            IR_IF        <= 32'd0;
            exc_pend_IF  <= 1'b0;
            exc_cause_IF <= 32'd0;
            if (((state == FETCH) || (state == KILL)) && !imem_ready) begin
                state <= KILL;
            end else begin
                state <= IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (pc[1:0] != 2'b00) begin
                        // Misaligned target: report it without touching memory.
                        valid_out    <= 1'b1;
                        PC_IF        <= pc;
                        IR_IF        <= 32'd0;
                        exc_pend_IF  <= 1'b1;
                        exc_cause_IF <= CAUSE_MISALIGNED_INST;
                        state        <= FULL;
                    end else begin
                        imem_addr <= pc;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (imem_ready) begin
                        valid_out <= 1'b1;
                        PC_IF     <= imem_addr;
                        if (imem_error) begin
                            IR_IF        <= 32'd0;
                            exc_pend_IF  <= 1'b1;
                            exc_cause_IF <= CAUSE_INST_ACCESS_FAULT;
                        end else begin
                            IR_IF        <= imem_rdata;
                            exc_pend_IF  <= 1'b0;
                            exc_cause_IF <= 32'd0;
                        end
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (ready_in) begin
                        valid_out    <= 1'b0;
                        PC_IF        <= 32'd0;
                        IR_IF        <= 32'd0;
                        exc_pend_IF  <= 1'b0;
                        exc_cause_IF <= 32'd0;
                        if (exc_pend_IF) begin
                            // Nothing sensible to fetch after a fault.
                            state <= HALT;
                        end else begin
                            pc    <= jump_pred_IF ? jump_addr_IF : (PC_IF + 32'd4);
                            state <= IDLE;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                KILL: begin
                    if (imem_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
